fp_norm_round: RTL and testbench
================================

FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 Parameter COARSE_SHIFT, default 8, SHALL set the left-shift step used when the top COARSE_SHIFT mantissa bits are all zero.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL qualify the raw sum/difference operand.
REQ-005 in_ready  output  1  SHALL be high only in IDLE.
REQ-006 in_sign  input  1  SHALL be the result sign from the add/sub datapath.
REQ-007 in_exp  input  11  SHALL be the biased exponent of the larger operand.
REQ-008 in_mant  input  56  SHALL be [55] carry, [54] hidden, [53:2] fraction, [1] guard, [0] sticky.
REQ-009 out_valid  output  1  SHALL qualify result and flags.
REQ-010 out_ready  input  1  SHALL be consumer acceptance.
REQ-011 result  output  64  SHALL be the IEEE-754 double {sign, exp[10:0], frac[51:0]}.
REQ-012 flag_ovf, flag_inexact, flag_zero  output  1 each  SHALL be overflow-to-infinity, guard|sticky nonzero before rounding, and zero result.

Function
REQ-013 FSM states SHALL be IDLE, NORM, ROUND, DONE.
REQ-014 IDLE: on in_valid&in_ready, latch inputs into internal mant (56b) and a 12-bit exponent set to max(in_exp,1); go to NORM.
REQ-015 NORM, mant==0: result {in_sign,63'b0}, flag_zero=1, flag_inexact=0; go to DONE.
REQ-016 NORM, mant[55]==1: shift right 1, new bit0 = old bit1|old bit0, exp+1; go to ROUND.
REQ-017 NORM, mant[54]==1 or exp==1: go to ROUND without shifting.
REQ-018 NORM, else if mant[54:55-COARSE_SHIFT]==0 and exp>COARSE_SHIFT: shift left COARSE_SHIFT, exp-COARSE_SHIFT; stay in NORM.
REQ-019 NORM, otherwise: shift left 1, exp-1; stay in NORM; left shifts SHALL fill zeros.
REQ-020 ROUND: round-to-nearest-even; increment mant[54:2] iff guard & (sticky | mant[2]); flag_inexact = guard|sticky.
REQ-021 A rounding carry out of bit 54 SHALL set the mantissa to hidden=1, fraction=0, and exp+1.
REQ-022 Encoded exponent SHALL be exp when hidden bit is 1, else 0 (subnormal); subnormal rounding into hidden bit yields encoded exp 1.
REQ-023 exp >= 2047 after ROUND SHALL produce {sign,11'h7FF,52'b0} with flag_ovf=1.
REQ-024 ROUND SHALL always go to DONE after one cycle.
REQ-025 DONE: out_valid=1, result and flags stable; on out_ready go to IDLE; hold indefinitely while out_ready=0.
REQ-026 Latency: accept at edge N; out_valid from edge N+3 when no left shift is needed, plus one cycle per left-shift step.
REQ-027 No new operand SHALL be accepted before the previous result completes the out_valid&out_ready handshake.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, and all flags=0, regardless of state.
REQ-029 Reset mid-NORM or mid-DONE SHALL discard the in-flight operand; no out_valid pulse for it after release.

Verification
REQ-030 in_mant=56'h40000000000000, exp=1023, sign=0 -> result 64'h3FF0000000000000 at N+3; flags 0.
REQ-031 in_mant=56'h80000000000000, exp=1023 -> result 64'h4000000000000000 (2.0); flag_inexact=0.
REQ-032 in_mant=56'h00000000000004, exp=1023, COARSE_SHIFT=8 -> 6 coarse + 4 single shifts; result 64'h3CB0000000000000 at N+13.
REQ-033 in_mant=56'h40000000000006, exp=1023 -> tie rounds to even: 64'h3FF0000000000002, flag_inexact=1.
REQ-034 in_mant=56'h7FFFFFFFFFFFFE, exp=2046 -> 64'h7FF0000000000000, flag_ovf=1, flag_inexact=1.
REQ-035 in_mant=0, sign=1 with out_ready=0 for 5 cycles -> 64'h8000000000000000, flag_zero=1, held stable, in_ready=0; then reset_n pulse mid-DONE -> out_valid=0, in_ready=1.

Source files
------------

// File: rtl/fp_norm_round.sv
// Normalises and rounds (RNE) a raw add/sub mantissa into an IEEE-754 double.
// Multi-cycle FSM: one operand in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_norm_round #(
  parameter int COARSE_SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [10:0] in_exp,
  input  logic [55:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        flag_ovf,
  output logic        flag_inexact,
  output logic        flag_zero
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic [55:0] mant, mant_nxt;
  logic [11:0] exp, exp_nxt;
  logic        sign, sign_nxt;
  logic [63:0] result_nxt;
  logic        ovf_nxt, inexact_nxt, zero_nxt;

  logic        round_inc;
  logic [53:0] rnd_sum;
  logic [11:0] rnd_exp;
  logic        rnd_hidden;
  logic [51:0] rnd_frac;
  logic        coarse_zero;

  // rnd_sum[53] is the carry out of the hidden bit; [52] is the hidden bit itself
  always_comb begin
    round_inc   = mant[1] & (mant[0] | mant[2]);
    rnd_sum     = {1'b0, mant[54:2]} + {53'd0, round_inc};
    rnd_exp     = exp + {11'd0, rnd_sum[53]};
    rnd_hidden  = rnd_sum[53] | rnd_sum[52];
    rnd_frac    = rnd_sum[53] ? 52'd0 : rnd_sum[51:0];
    coarse_zero = ~|mant[54:55-COARSE_SHIFT];
  end

  always_comb begin
    state_nxt   = state;
    mant_nxt    = mant;
    exp_nxt     = exp;
    sign_nxt    = sign;
    result_nxt  = result;
    ovf_nxt     = flag_ovf;
    inexact_nxt = flag_inexact;
    zero_nxt    = flag_zero;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mant_nxt  = in_mant;
          exp_nxt   = (in_exp == 11'd0) ? 12'd1 : {1'b0, in_exp};
          sign_nxt  = in_sign;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (mant == 56'd0) begin
          result_nxt  = {sign, 63'd0};
          ovf_nxt     = 1'b0;
          inexact_nxt = 1'b0;
          zero_nxt    = 1'b1;
          state_nxt   = DONE;
        end else if (mant[55]) begin
          mant_nxt  = {1'b0, mant[55:2], mant[1] | mant[0]};
          exp_nxt   = exp + 12'd1;
          state_nxt = ROUND;
        end else if (mant[54] || exp == 12'd1) begin
          state_nxt = ROUND;
        end else if (coarse_zero && exp > 12'(COARSE_SHIFT)) begin
          mant_nxt = mant << COARSE_SHIFT;
          exp_nxt  = exp - 12'(COARSE_SHIFT);
        end else begin
          mant_nxt = {mant[54:0], 1'b0};
          exp_nxt  = exp - 12'd1;
        end
      end
      ROUND: begin
        inexact_nxt = mant[1] | mant[0];
        zero_nxt    = 1'b0;
        if (rnd_exp >= 12'd2047) begin
          result_nxt = {sign, 11'h7FF, 52'd0};
          ovf_nxt    = 1'b1;
        end else begin
          // a subnormal that rounds into the hidden bit keeps exp==1, which is its correct encoding
          result_nxt = {sign, rnd_hidden ? rnd_exp[10:0] : 11'd0, rnd_frac};
          ovf_nxt    = 1'b0;
        end
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mant         <= 56'd0;
      exp          <= 12'd0;
      sign         <= 1'b0;
      result       <= 64'd0;
      flag_ovf     <= 1'b0;
      flag_inexact <= 1'b0;
      flag_zero    <= 1'b0;
    end else begin
      state        <= state_nxt;
      mant         <= mant_nxt;
      exp          <= exp_nxt;
      sign         <= sign_nxt;
      result       <= result_nxt;
      flag_ovf     <= ovf_nxt;
      flag_inexact <= inexact_nxt;
      flag_zero    <= zero_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed-vector bench for fp_norm_round; expected results hand-computed from IEEE-754 encoding.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [10:0] in_exp;
  logic [55:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        flag_ovf, flag_inexact, flag_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_norm_round #(.COARSE_SHIFT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_ovf(flag_ovf), .flag_inexact(flag_inexact), .flag_zero(flag_zero)
  );

  // Present one operand, then count negedges until out_valid (lat=k means seen at edge N+k); 0 = timeout.
  task automatic run_op(input logic s, input logic [10:0] e, input logic [55:0] m, output int lat);
    @(negedge clk);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs: got %b want 10", {in_ready, out_valid});
    else n_pass++;
    n_checks++;
    if (result !== 64'd0) $display("FAIL reset_result: got %h want 0", result);
    else n_pass++;
    n_checks++;
    if ({flag_ovf, flag_inexact, flag_zero} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {flag_ovf, flag_inexact, flag_zero});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_one();
    int lat;
    run_op(1'b0, 11'd1023, 56'h40000000000000, lat);
    n_checks++;
    if (lat !== 3) $display("FAIL one_latency: got %0d want 3", lat);
    else n_pass++;
    n_checks++;
    if (result !== 64'h3FF0000000000000) $display("FAIL one_result: got %h want 3ff0000000000000", result);
    else n_pass++;
    n_checks++;
    if ({flag_ovf, flag_inexact, flag_zero} !== 3'b000)
      $display("FAIL one_flags: got %b want 000", {flag_ovf, flag_inexact, flag_zero});
    else n_pass++;
    finish_op();
  endtask

  task automatic test_carry();
    int lat;
    run_op(1'b0, 11'd1023, 56'h80000000000000, lat);
    n_checks++;
    if (lat !== 3) $display("FAIL carry_latency: got %0d want 3", lat);
    else n_pass++;
    n_checks++;
    if (result !== 64'h4000000000000000) $display("FAIL carry_result: got %h want 4000000000000000", result);
    else n_pass++;
    n_checks++;
    if ({flag_ovf, flag_inexact, flag_zero} !== 3'b000)
      $display("FAIL carry_flags: got %b want 000", {flag_ovf, flag_inexact, flag_zero});
    else n_pass++;
    finish_op();
    // guard/sticky folded by the right shift, then rounded up
    run_op(1'b0, 11'd1023, 56'h80000000000006, lat);
    n_checks++;
    if (result !== 64'h4000000000000001) $display("FAIL carry_sticky_result: got %h want 4000000000000001", result);
    else n_pass++;
    n_checks++;
    if ({flag_ovf, flag_inexact, flag_zero} !== 3'b010)
      $display("FAIL carry_sticky_flags: got %b want 010", {flag_ovf, flag_inexact, flag_zero});
    else n_pass++;
    finish_op();
  endtask

  task automatic test_shift();
    int lat;
    run_op(1'b0, 11'd1023, 56'h00000000000004, lat);
    n_checks++;
    if (lat !== 13) $display("FAIL shift_latency: got %0d want 13", lat);
    else n_pass++;
    n_checks++;
    if (result !== 64'h3CB0000000000000) $display("FAIL shift_result: got %h want 3cb0000000000000", result);
    else n_pass++;
    finish_op();
    // exp=5 blocks the coarse step: 4 single shifts down to exp 1, subnormal
    run_op(1'b0, 11'd5, 56'h00000000000004, lat);
    n_checks++;
    if (lat !== 7) $display("FAIL shift_exp5_latency: got %0d want 7", lat);
    else n_pass++;
    n_checks++;
    if (result !== 64'h0000000000000010) $display("FAIL shift_exp5_result: got %h want 0000000000000010", result);
    else n_pass++;
    finish_op();
    // exp=9 allows one coarse step landing exactly on exp 1
    run_op(1'b0, 11'd9, 56'h00000000000004, lat);
    n_checks++;
    if (lat !== 4) $display("FAIL shift_exp9_latency: got %0d want 4", lat);
    else n_pass++;
    n_checks++;
    if (result !== 64'h0000000000000100) $display("FAIL shift_exp9_result: got %h want 0000000000000100", result);
    else n_pass++;
    finish_op();
  endtask

  task automatic test_round();
    int lat;
    run_op(1'b0, 11'd1023, 56'h40000000000006, lat);
    n_checks++;
    if (result !== 64'h3FF0000000000002) $display("FAIL round_tie_odd: got %h want 3ff0000000000002", result);
    else n_pass++;
    n_checks++;
    if ({flag_ovf, flag_inexact, flag_zero} !== 3'b010)
      $display("FAIL round_tie_odd_flags: got %b want 010", {flag_ovf, flag_inexact, flag_zero});
    else n_pass++;
    finish_op();
    run_op(1'b0, 11'd1023, 56'h40000000000002, lat);
    n_checks++;
    if (result !== 64'h3FF0000000000000) $display("FAIL round_tie_even: got %h want 3ff0000000000000", result);
    else n_pass++;
    n_checks++;
    if (flag_inexact !== 1'b1) $display("FAIL round_tie_even_inexact: got %b want 1", flag_inexact);
    else n_pass++;
    finish_op();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(1'b0, 11'd2046, 56'h7FFFFFFFFFFFFE, lat);
    n_checks++;
    if (result !== 64'h7FF0000000000000) $display("FAIL ovf_result: got %h want 7ff0000000000000", result);
    else n_pass++;
    n_checks++;
    if ({flag_ovf, flag_inexact, flag_zero} !== 3'b110)
      $display("FAIL ovf_flags: got %b want 110", {flag_ovf, flag_inexact, flag_zero});
    else n_pass++;
    finish_op();
  endtask

  task automatic test_subnormal();
    int lat;
    run_op(1'b0, 11'd0, 56'h3FFFFFFFFFFFFF, lat);
    n_checks++;
    if (result !== 64'h0010000000000000) $display("FAIL subn_round_up: got %h want 0010000000000000", result);
    else n_pass++;
    n_checks++;
    if (flag_inexact !== 1'b1) $display("FAIL subn_round_up_inexact: got %b want 1", flag_inexact);
    else n_pass++;
    finish_op();
    run_op(1'b1, 11'd0, 56'h00000000000004, lat);
    n_checks++;
    if (result !== 64'h8000000000000001) $display("FAIL subn_min: got %h want 8000000000000001", result);
    else n_pass++;
    finish_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic ok;
    run_op(1'b0, 11'd1023, 56'h40000000000000, lat);
    @(negedge clk);
    in_sign = 1'b1; in_exp = 11'd100; in_mant = 56'h40000000000006; in_valid = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== 64'h3FF0000000000000) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL b2b_no_accept: got out_valid=%b in_ready=%b result=%h", out_valid, in_ready, result);
    else n_pass++;
    in_valid = 1'b0;
    finish_op();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL b2b_idle: got %b want 10", {in_ready, out_valid});
    else n_pass++;
    run_op(1'b0, 11'd1024, 56'h40000000000000, lat);
    n_checks++;
    if (result !== 64'h4000000000000000) $display("FAIL b2b_second: got %h want 4000000000000000", result);
    else n_pass++;
    finish_op();
  endtask

  task automatic test_zero_hold_reset();
    int lat;
    logic ok;
    run_op(1'b1, 11'd1023, 56'd0, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL zero_latency: got %0d want 2", lat);
    else n_pass++;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== 64'h8000000000000000 || {flag_ovf, flag_inexact, flag_zero} !== 3'b001)
        ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL zero_hold: got result=%h flags=%b in_ready=%b", result, {flag_ovf, flag_inexact, flag_zero}, in_ready);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, flag_zero} !== 3'b100 || result !== 64'd0)
      $display("FAIL zero_reset: got rdy/vld/zero=%b result=%h want 100 0", {in_ready, out_valid, flag_zero}, result);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_norm();
    logic seen;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 11'd1023; in_mant = 56'h00000000000004; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) $display("FAIL norm_reset_discard: got seen=%b in_ready=%b want 0 1", seen, in_ready);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_one();
    test_carry();
    test_shift();
    test_round();
    test_overflow();
    test_subnormal();
    test_back_to_back();
    test_zero_hold_reset();
    test_reset_mid_norm();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
